// File: rtl/rx_pkg.sv
// Mode encodings and receive-FSM states, shared by the Rx deframer and the Tx framer.
package rx_pkg;

    localparam logic [3:0] MODE_BPSK = 4'b0001;
    localparam logic [3:0] MODE_QPSK = 4'b0010;
    localparam logic [3:0] MODE_MIX  = 4'b0100;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CHK     = 2'd3
    } rx_state_t;

    // Unknown mode codes collapse to BPSK so downstream logic sees only three values.
    function automatic logic [3:0] norm_mode(input logic [3:0] m);
        logic [3:0] r;
        if (m == MODE_QPSK || m == MODE_MIX) r = m;
        else r = MODE_BPSK;
        return r;
    endfunction

    // MIX carries sync and length at 1 bit/symbol, payload and checksum at 2 bits/symbol.
    function automatic logic dual_bit(input logic [3:0] mode, input rx_state_t st);
        return (mode == MODE_QPSK) ||
               (mode == MODE_MIX && (st == ST_PAYLOAD || st == ST_CHK));
    endfunction

endpackage

// File: rtl/rx_bit_packer.sv
// Packs 1 or 2 bits per strobe, MSB first, into bytes; flags the strobe that completes a byte.
module rx_bit_packer (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       dual,
    input  logic [1:0] bits,
    output logic [7:0] byte_out,
    output logic       byte_done
);

    logic [7:0] shreg;
    logic [7:0] shreg_next;
    logic [2:0] cnt;
    logic [3:0] cnt_next;

    always_comb begin
        shreg_next = {shreg[6:0], bits[0]};
        cnt_next   = {1'b0, cnt} + 4'd1;
        if (dual) begin
            shreg_next = {shreg[5:0], bits[1], bits[0]};
            cnt_next   = {1'b0, cnt} + 4'd2;
        end
    end

    // The completed byte is presented combinationally so the FSM can act on it this cycle.
    assign byte_out  = shreg_next;
    assign byte_done = en && (cnt_next == 4'd8);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            shreg <= 8'd0;
            cnt   <= 3'd0;
        end else if (en) begin
            shreg <= shreg_next;
            cnt   <= byte_done ? 3'd0 : cnt_next[2:0];
        end
    end

endmodule

// File: rtl/rx_deframer.sv
// Hunts for the sync word, then extracts LEN-byte payloads and verifies the XOR checksum.
module rx_deframer
    import rx_pkg::*;
#(
    parameter logic [15:0] SYNC_WORD = 16'hEB90
) (
    input  logic        clk_16M384,
    input  logic        rst_16M384,
    input  logic [3:0]  MODE_CTRL,
    input  logic        sym_vld,
    input  logic [1:0]  sym_bits,
    output logic [7:0]  data_tdata,
    output logic        data_tvalid,
    output logic        data_tlast,
    output logic        data_tuser,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt,
    output rx_state_t   dbg_state
);

    // Output stream: data_tvalid is a one-cycle pulse with no ready; tdata/tuser/tlast
    // are meaningful only while data_tvalid is high.

    rx_state_t   state;
    logic [15:0] window;
    logic [15:0] window_next;
    logic [3:0]  mode_q;
    logic [3:0]  hunt_mode;
    logic        dual;
    logic [7:0]  remaining;
    logic [7:0]  running_xor;
    logic        first_byte;
    logic [7:0]  rx_byte;
    logic        byte_done;

    assign dbg_state = state;
    assign hunt_mode = norm_mode(MODE_CTRL);
    // While hunting, the live mode decides symbol width; afterwards only the latched one.
    assign dual = (state == ST_HUNT) ? dual_bit(hunt_mode, ST_HUNT) : dual_bit(mode_q, state);

    always_comb begin
        window_next = {window[14:0], sym_bits[0]};
        if (dual) window_next = {window[13:0], sym_bits[1], sym_bits[0]};
    end

    rx_bit_packer u_packer (
        .clk       (clk_16M384),
        .rst       (rst_16M384),
        .clr       (state == ST_HUNT),
        .en        (sym_vld && (state != ST_HUNT)),
        .dual      (dual),
        .bits      (sym_bits),
        .byte_out  (rx_byte),
        .byte_done (byte_done)
    );

    always_ff @(posedge clk_16M384) begin
        if (rst_16M384) begin
            state       <= ST_HUNT;
            window      <= 16'd0;
            mode_q      <= 4'd0;
            remaining   <= 8'd0;
            running_xor <= 8'd0;
            first_byte  <= 1'b0;
            data_tdata  <= 8'd0;
            data_tvalid <= 1'b0;
            data_tlast  <= 1'b0;
            data_tuser  <= 1'b0;
            frame_ok    <= 1'b0;
            frame_err   <= 1'b0;
            frame_cnt   <= 16'd0;
            err_cnt     <= 16'd0;
        end else begin
            data_tdata  <= 8'd0;
            data_tvalid <= 1'b0;
            data_tlast  <= 1'b0;
            data_tuser  <= 1'b0;
            frame_ok    <= 1'b0;
            frame_err   <= 1'b0;
            if (sym_vld) begin
                case (state)
                    ST_HUNT: begin
                        if (window_next == SYNC_WORD) begin
                            // Clearing the window keeps frame bits out of the next hunt.
                            window      <= 16'd0;
                            mode_q      <= hunt_mode;
                            running_xor <= 8'd0;
                            state       <= ST_LEN;
                        end else begin
                            window <= window_next;
                        end
                    end
                    ST_LEN: begin
                        if (byte_done) begin
                            if (rx_byte == 8'd0) begin
                                frame_err <= 1'b1;
                                err_cnt   <= err_cnt + 16'd1;
                                state     <= ST_HUNT;
                            end else begin
                                remaining   <= rx_byte;
                                running_xor <= rx_byte;
                                first_byte  <= 1'b1;
                                state       <= ST_PAYLOAD;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        if (byte_done) begin
                            data_tvalid <= 1'b1;
                            data_tdata  <= rx_byte;
                            data_tuser  <= first_byte;
                            data_tlast  <= (remaining == 8'd1);
                            first_byte  <= 1'b0;
                            running_xor <= running_xor ^ rx_byte;
                            remaining   <= remaining - 8'd1;
                            if (remaining == 8'd1) state <= ST_CHK;
                        end
                    end
                    ST_CHK: begin
                        if (byte_done) begin
                            if (rx_byte == running_xor) begin
                                frame_ok  <= 1'b1;
                                frame_cnt <= frame_cnt + 16'd1;
                            end else begin
                                frame_err <= 1'b1;
                                err_cnt   <= err_cnt + 16'd1;
                            end
                            state <= ST_HUNT;
                        end
                    end
                    default: state <= ST_HUNT;
                endcase
            end
        end
    end

endmodule
